// File: rtl/histogram_bank_ctrl_if.sv
// Magnitude stream into the histogram bank controller: FFT side is master,
// controller is slave.
interface histogram_bank_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/histogram_bank_ctrl.sv
// Ping-pong bank controller for the 2x1024-bin histogram RAM; banks swap only at vblank.
// Optional macro HIST_STATS_EN adds swap/stale 16-bit counters.
module histogram_bank_ctrl #(
  parameter int BIN_W  = 10,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  histogram_bank_ctrl_if.slave s,
  input  logic               vblank_start,
  output logic               wr_en,
  output logic [BIN_W:0]     wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  input  logic [BIN_W-1:0]   rd_bin,
  output logic [BIN_W:0]     rd_addr,
  output logic               front_bank,
  output logic               frame_ready,
  output logic               sync_err,
  output logic [15:0]        swap_count,
  output logic [15:0]        stale_count
);

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

  localparam logic [BIN_W-1:0] IDX_MAX = {BIN_W{1'b1}};

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  idx_q, idx_d;
  logic              front_q, front_d;
  logic              wr_en_q, wr_en_d;
  logic [BIN_W:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              sync_err_q, sync_err_d;
  logic              accept;

  assign s.s_ready   = (state_q != HOLD);
  assign frame_ready = (state_q == HOLD);
  assign accept      = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      idx_q      <= '0;
      front_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      front_q    <= front_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    front_d    = front_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    sync_err_d = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~front_q, idx_q};
          wr_data_d = s.s_data;
          idx_d     = idx_q + 1'b1;
          if (idx_q == IDX_MAX) begin
            idx_d = '0;
            if (s.s_last) begin
              state_d = HOLD;
            end else begin
              sync_err_d = 1'b1;
              state_d    = DRAIN;
            end
          end else if (s.s_last) begin
            // Short frame: restart at bin 0, the partial data is overwritten.
            idx_d      = '0;
            sync_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s.s_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (vblank_start) begin
          front_d = ~front_q;
          state_d = FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign sync_err   = sync_err_q;
  assign front_bank = front_q;
  assign rd_addr    = {front_q, rd_bin};

`ifdef HIST_STATS_EN
  logic [15:0] swap_q, stale_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_q  <= '0;
      stale_q <= '0;
    end else if (vblank_start) begin
      if (state_q == HOLD) swap_q  <= swap_q + 16'd1;
      else                 stale_q <= stale_q + 16'd1;
    end
  end

  assign swap_count  = swap_q;
  assign stale_count = stale_q;
`else
  assign swap_count  = '0;
  assign stale_count = '0;
`endif

endmodule

// File: tb/tb_histogram_bank_ctrl.sv
// Randomized self-checking bench for histogram_bank_ctrl against a frame-level
// reference model of bank filling, framing errors and vblank swaps.
module tb_histogram_bank_ctrl;

`ifdef HIST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vblank_start = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic [9:0]  rd_bin = '0;
  logic [10:0] rd_addr;
  logic        front_bank, frame_ready, sync_err;
  logic [15:0] swap_count, stale_count;

  histogram_bank_ctrl_if #(.DATA_W(16)) sif ();

  histogram_bank_ctrl #(.BIN_W(10), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(sif.slave), .vblank_start(vblank_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_bin(rd_bin),
    .rd_addr(rd_addr), .front_bank(front_bank), .frame_ready(frame_ready),
    .sync_err(sync_err), .swap_count(swap_count), .stale_count(stale_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame position, pending-full flag, dropping flag, bank and counters.
  int          m_front, m_pos, m_swaps, m_stale;
  bit          m_full, m_drop;
  bit          exp_ready, obs_ready, exp_wr_en, exp_sync;
  logic [10:0] exp_addr;
  logic [15:0] exp_data;

  function automatic logic [15:0] exp_swc();
    return STATS ? 16'(m_swaps) : 16'd0;
  endfunction

  function automatic logic [15:0] exp_stc();
    return STATS ? 16'(m_stale) : 16'd0;
  endfunction

  task automatic m_reset();
    m_front = 0; m_pos = 0; m_swaps = 0; m_stale = 0;
    m_full = 0; m_drop = 0;
    exp_wr_en = 0; exp_sync = 0; exp_addr = '0; exp_data = '0;
  endtask

  // Drives one cycle from a negedge to the next negedge and advances the model.
  task automatic step(input bit v, input logic [15:0] d, input bit l, input bit vb);
    sif.s_valid = v; sif.s_data = d; sif.s_last = l; vblank_start = vb;
    #1;
    obs_ready = sif.s_ready;
    exp_ready = !m_full;
    exp_wr_en = 0;
    exp_sync  = 0;
    if (m_full) begin
      if (vb) begin
        m_front = 1 - m_front; m_swaps++; m_full = 0; m_pos = 0;
      end
    end else begin
      if (vb) m_stale++;
      if (v) begin
        if (m_drop) begin
          if (l) begin m_drop = 0; m_pos = 0; end
        end else begin
          exp_wr_en = 1;
          exp_addr  = 11'((1 - m_front) * 1024 + m_pos);
          exp_data  = d;
          if (m_pos == 1023) begin
            m_pos = 0;
            if (l) m_full = 1;
            else begin exp_sync = 1; m_drop = 1; end
          end else if (l) begin
            exp_sync = 1; m_pos = 0;
          end else m_pos++;
        end
      end
    end
    @(negedge clk);
    sif.s_valid = 1'b0; vblank_start = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step(1'b0, 16'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0; vblank_start = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    n_vec++;
    if ({front_bank, wr_en, wr_addr, wr_data, sync_err, sif.s_ready, frame_ready} !== {1'b0, 1'b0, 11'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs got fb=%b we=%b a=%h d=%h se=%b rdy=%b fr=%b exp 0 0 000 0000 0 1 0",
               front_bank, wr_en, wr_addr, wr_data, sync_err, sif.s_ready, frame_ready);
    end
    n_vec++;
    if ({swap_count, stale_count} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_counters got %h %h exp 0 0", swap_count, stale_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'(b * 3), b == 1023, 1'b0);
      n_vec++;
      if ({obs_ready, wr_en, wr_addr, wr_data, sync_err} !== {exp_ready, exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL full_beat bin=%0d got rdy=%b we=%b a=%h d=%h se=%b exp rdy=%b we=%b a=%h d=%h se=%b",
                 b, obs_ready, wr_en, wr_addr, wr_data, sync_err, exp_ready, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'($urandom), 1'($urandom), 1'b0);
      n_vec++;
      if ({obs_ready, frame_ready, wr_en} !== {1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL hold_state got rdy=%b fr=%b we=%b exp 0 1 0", obs_ready, frame_ready, wr_en);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({front_bank, frame_ready, sif.s_ready} !== {1'(m_front), 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL first_swap got fb=%b fr=%b rdy=%b exp fb=%b fr=0 rdy=1", front_bank, frame_ready, sif.s_ready, 1'(m_front));
    end
    rd_bin = 10'd5;
    #1;
    n_vec++;
    if (rd_addr !== 11'h405) begin
      n_err++;
      $display("FAIL rd_addr_5 got %h exp 405", rd_addr);
    end
    for (int i = 0; i < 4; i++) begin
      rd_bin = 10'($urandom);
      #1;
      n_vec++;
      if (rd_addr !== 11'(m_front * 1024 + int'(rd_bin))) begin
        n_err++;
        $display("FAIL rd_addr_rand bin=%h got %h exp %h", rd_bin, rd_addr, 11'(m_front * 1024 + int'(rd_bin)));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_second_frame();
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'($urandom), b == 1023, 1'b0);
      n_vec++;
      if ({obs_ready, wr_en, wr_addr, wr_data, sync_err} !== {exp_ready, exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL second_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    repeat ($urandom_range(1, 4)) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({front_bank, swap_count} !== {1'(m_front), exp_swc()}) begin
      n_err++;
      $display("FAIL second_swap got fb=%b swaps=%0d exp fb=%b swaps=%0d", front_bank, swap_count, 1'(m_front), exp_swc());
    end
  endtask

  task automatic test_short_frame();
    for (int b = 0; b <= 500; b++) begin
      gap();
      step(1'b1, 16'($urandom), b == 500, 1'b0);
      n_vec++;
      if ({wr_en, wr_addr, wr_data, sync_err} !== {exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL short_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    step(1'b0, '0, 1'b0, 1'b0);
    n_vec++;
    if (sync_err !== 1'b0) begin
      n_err++;
      $display("FAIL short_pulse_width got se=%b exp 0", sync_err);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({front_bank, stale_count, frame_ready} !== {1'(m_front), exp_stc(), 1'b0}) begin
      n_err++;
      $display("FAIL short_stale got fb=%b stale=%0d fr=%b exp fb=%b stale=%0d fr=0",
               front_bank, stale_count, frame_ready, 1'(m_front), exp_stc());
    end
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'($urandom), b == 1023, 1'b0);
      n_vec++;
      if ({wr_en, wr_addr, wr_data, sync_err} !== {exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL after_short_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({front_bank, swap_count} !== {1'(m_front), exp_swc()}) begin
      n_err++;
      $display("FAIL short_recover_swap got fb=%b swaps=%0d exp fb=%b swaps=%0d", front_bank, swap_count, 1'(m_front), exp_swc());
    end
  endtask

  task automatic test_long_frame();
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'($urandom), 1'b0, 1'b0);
      n_vec++;
      if ({wr_en, wr_addr, wr_data, sync_err} !== {exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL long_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    for (int k = 0; k < 10; k++) begin
      gap();
      step(1'b1, 16'($urandom), k == 9, 1'b0);
      n_vec++;
      if ({obs_ready, wr_en, sync_err} !== {1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL drain_beat k=%0d got rdy=%b we=%b se=%b exp 1 0 0", k, obs_ready, wr_en, sync_err);
      end
    end
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'($urandom), b == 1023, 1'b0);
      n_vec++;
      if ({wr_en, wr_addr, wr_data, sync_err} !== {exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL after_drain_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if (front_bank !== 1'(m_front)) begin
      n_err++;
      $display("FAIL long_recover_swap got fb=%b exp %b", front_bank, 1'(m_front));
    end
  endtask

  task automatic test_vblank_coincident();
    int fb_before;
    fb_before = m_front;
    for (int b = 0; b < 1024; b++) begin
      gap();
      step(1'b1, 16'($urandom), b == 1023, b == 1023);
      n_vec++;
      if ({wr_en, wr_addr, wr_data, sync_err} !== {exp_wr_en, exp_addr, exp_data, exp_sync}) begin
        n_err++;
        $display("FAIL coinc_beat bin=%0d got we=%b a=%h d=%h se=%b exp we=%b a=%h d=%h se=%b",
                 b, wr_en, wr_addr, wr_data, sync_err, exp_wr_en, exp_addr, exp_data, exp_sync);
      end
    end
    n_vec++;
    if ({front_bank, frame_ready, stale_count} !== {1'(fb_before), 1'b1, exp_stc()}) begin
      n_err++;
      $display("FAIL coinc_no_toggle got fb=%b fr=%b stale=%0d exp fb=%b fr=1 stale=%0d",
               front_bank, frame_ready, stale_count, 1'(fb_before), exp_stc());
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_vec++;
    if ({front_bank, swap_count} !== {~1'(fb_before), exp_swc()}) begin
      n_err++;
      $display("FAIL coinc_next_toggle got fb=%b swaps=%0d exp fb=%b swaps=%0d",
               front_bank, swap_count, ~1'(fb_before), exp_swc());
    end
  endtask

  task automatic test_reset_midframe();
    for (int b = 0; b <= 700; b++) begin
      gap();
      step(1'b1, 16'($urandom), 1'b0, 1'b0);
    end
    n_vec++;
    if (wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_write got we=%b exp 1", wr_en);
    end
    reset_n = 1'b0;
    #2;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, front_bank} !== {1'b0, 11'h0, 16'h0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset got we=%b a=%h d=%h fb=%b exp 0 000 0000 0", wr_en, wr_addr, wr_data, front_bank);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    @(negedge clk);
    n_vec++;
    if ({front_bank, sif.s_ready, wr_en, swap_count, stale_count} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL post_reset got fb=%b rdy=%b we=%b swaps=%0d stale=%0d exp 0 1 0 0 0",
               front_bank, sif.s_ready, wr_en, swap_count, stale_count);
    end
    for (int b = 0; b < 3; b++) begin
      step(1'b1, 16'($urandom), 1'b0, 1'b0);
      n_vec++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 11'(1024 + b), exp_data}) begin
        n_err++;
        $display("FAIL post_reset_beat bin=%0d got we=%b a=%h d=%h exp 1 %h %h", b, wr_en, wr_addr, wr_data, 11'(1024 + b), exp_data);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_second_frame();
    test_short_frame();
    test_long_frame();
    test_vblank_coincident();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/histogram_bank_ctrl.md
Name: histogram_bank_ctrl

Overview:
- Ping-pong controller for the 2x1024-bin magnitude RAM that feeds the VGA histogram renderer.
- Accepts one FFT magnitude frame (bins 0..1023, in order) over a valid/ready stream and writes it into the back bank.
- Swaps front/back banks only at the start of vertical blank, so the display never shows a partially written spectrum.
- Converts the renderer's 10-bit bin index into an 11-bit RAM address with the front-bank bit prepended.

Parameters:
- BIN_W, 10, bin index width (1024 bins per bank).
- DATA_W, 16, magnitude width.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  magnitude beat valid.
- s_data  in  DATA_W  magnitude for the current bin.
- s_last  in  1  marks bin 1023 of a frame.
- s_ready  out  1  controller can accept a beat.
- vblank_start  in  1  one-cycle pulse at start of vertical blank.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  BIN_W+1  {back_bank, bin}.
- wr_data  out  DATA_W  RAM write data.
- rd_bin  in  BIN_W  bin requested by the renderer (hcount[9:0]).
- rd_addr  out  BIN_W+1  {front_bank, rd_bin}, combinational.
- front_bank  out  1  bank currently displayed.
- frame_ready  out  1  back bank complete, awaiting swap.
- sync_err  out  1  one-cycle pulse on framing error.
- swap_count  out  16  completed swaps (HIST_STATS_EN).
- stale_count  out  16  vblanks with no new frame (HIST_STATS_EN).

Behaviour:
- Reset (asynchronous, on reset_n low): state=FILL, idx=0, front_bank=0, wr_en=0, wr_addr=0, wr_data=0, sync_err=0, counters=0. A reset asserted mid-frame discards the partial frame; the bank contents are don't-care.
- Accept means s_valid && s_ready.
- Back bank = ~front_bank.
- FILL state:
  - s_ready=1, frame_ready=0.
  - On accept, the next edge registers wr_en=1, wr_addr={~front_bank, idx}, wr_data=s_data; idx increments. Write latency is 1 cycle.
  - Accept with idx==1023 and s_last=1 -> HOLD, idx=0.
  - Accept with s_last=1 and idx!=1023 (short frame) -> sync_err pulse, idx=0, stay FILL. The partial frame is overwritten by the next one.
  - Accept with idx==1023 and s_last=0 (long frame) -> sync_err pulse, go to DRAIN.
- DRAIN state:
  - s_ready=1, wr_en=0. Beats are discarded until an accept with s_last=1, then FILL with idx=0.
- HOLD state:
  - s_ready=0, frame_ready=1.
  - On vblank_start: front_bank toggles at the next edge, then FILL with idx=0.
- Swap rules:
  - vblank_start in FILL or DRAIN: no swap. Increments stale_count.
  - The final beat accepted in the same cycle as vblank_start does not swap; the swap waits for the next vblank_start in HOLD.
  - Because the final write is issued on the edge that enters HOLD, it always lands before the swap.
- wr_en is high only for the one cycle following each FILL accept; otherwise 0.
- rd_addr tracks front_bank combinationally. front_bank changes only at vblank, so the display sees a stable bank for the whole active frame.
- Counters are 16-bit and wrap 0xFFFF -> 0.

Optional Feature:
- Macro: HIST_STATS_EN.
- Defined: swap_count increments on each bank toggle; stale_count increments on each vblank_start seen outside HOLD.
- Undefined: both counter ports are tied to 0 and no counter registers are synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, stream bins 0..1023 with data=bin*3, s_last on 1023 -> 1024 writes at wr_addr 0x400..0x7FF, data matches; frame_ready=1, s_ready=0. Then vblank_start -> front_bank=1 next cycle, rd_bin=5 gives rd_addr=0x405.
- Second full frame after swap -> writes target 0x000..0x3FF; second vblank -> front_bank=0. With HIST_STATS_EN, swap_count=2.
- s_last on bin 500 -> sync_err one pulse, next frame writes start at bin 0; no swap on the following vblank; stale_count=1.
- Bin 1023 without s_last, then 10 more beats with the last one carrying s_last -> sync_err pulse, the 10 beats cause no wr_en, then FILL resumes at idx 0.
- vblank_start coincident with the accept of bin 1023 -> no toggle that cycle; toggle only on the next vblank_start.
- reset_n low at bin 700, release -> front_bank=0, idx=0, s_ready=1, wr_en=0, counters=0.
